// File: rtl/ika9958_rcc_gen.sv
// ika9958_rcc_gen: clock/reset control; i_XTAL1 clock, i_RST sync reset, i_XTAL_NCEN advance enable -> o_PHASE, DHCLK/DLCLK levels and edge enables, stretched o_RST_INT, o_LOCKED; the i_DLCLK_n/i_SLAVE phase lock is built only with IKA9958_EXTSYNC_EN
module ika9958_rcc_gen #(
  parameter int DIV = 4,
  parameter int RST_STRETCH = 16,
  parameter int LOCK_PHASE = (DIV/2+2)%DIV,
  parameter int LOCK_CNT = 3
)(
  input  logic                    i_XTAL1,
  input  logic                    i_RST,
  input  logic                    i_XTAL_NCEN,
  input  logic                    i_DLCLK_n,
  input  logic                    i_SLAVE,
  output logic [$clog2(DIV)-1:0]  o_PHASE,
  output logic                    o_DHCLK_n,
  output logic                    o_DLCLK_n,
  output logic                    o_DHCLK_PCEN,
  output logic                    o_DHCLK_NCEN,
  output logic                    o_DLCLK_PCEN,
  output logic                    o_DLCLK_NCEN,
  output logic                    o_RST_INT,
  output logic                    o_LOCKED
);
  localparam int PW = $clog2(DIV);
  localparam int RW = $clog2(RST_STRETCH+1);
  logic adv, en, load;
  logic [PW-1:0] phase_inc;
  logic [RW-1:0] rcnt;
  assign adv = ~i_XTAL_NCEN;
  assign en = adv & ~i_RST;
  assign phase_inc = (o_PHASE == PW'(DIV-1)) ? '0 : o_PHASE + 1'b1;
  assign o_DHCLK_n = ~o_PHASE[0];
  assign o_DLCLK_n = o_PHASE < PW'(DIV/2);
  assign o_DHCLK_NCEN = en & ~o_PHASE[0];
  assign o_DHCLK_PCEN = en & o_PHASE[0];
  assign o_DLCLK_NCEN = en & (o_PHASE == PW'(DIV/2-1));
  assign o_DLCLK_PCEN = en & (o_PHASE == PW'(DIV-1));
  assign o_RST_INT = i_RST | (rcnt != '0);
  always_ff @(posedge i_XTAL1) begin
    if (i_RST) begin
      o_PHASE <= '0;
      rcnt <= RW'(RST_STRETCH);
    end else if (adv) begin
      o_PHASE <= load ? PW'(LOCK_PHASE) : phase_inc;
      rcnt <= (rcnt != '0) ? rcnt - 1'b1 : rcnt;
    end
  end
`ifdef IKA9958_EXTSYNC_EN
  localparam int MW = $clog2(LOCK_CNT+1);
  localparam int TW = $clog2(2*DIV);
  localparam logic [1:0] UNLOCKED = 2'd0, TRACK = 2'd1, LOCKED = 2'd2;
  logic [1:0] sync, state;
  logic [MW-1:0] mcnt;
  logic [TW-1:0] tcnt;
  logic dl_prev, pend, slave_q, fall, chg, pend_eff, match, timeout;
  assign fall = dl_prev & ~sync[1];
  assign chg = i_SLAVE ^ slave_q;
  assign pend_eff = pend | fall;
  assign load = i_SLAVE & ~chg & adv & pend_eff;
  assign match = phase_inc == PW'(LOCK_PHASE);
  assign timeout = adv & ~load & (tcnt == TW'(2*DIV-1));
  assign o_LOCKED = i_SLAVE ? (state == LOCKED) : ~o_RST_INT;
  always_ff @(posedge i_XTAL1) begin
    if (i_RST) begin
      sync <= 2'b11;
      dl_prev <= 1'b1;
      pend <= 1'b0;
      slave_q <= i_SLAVE;
      state <= UNLOCKED;
      mcnt <= '0;
      tcnt <= '0;
    end else begin
      sync <= {sync[0], i_DLCLK_n};
      dl_prev <= sync[1];
      slave_q <= i_SLAVE;
      if (~i_SLAVE | chg) begin
        pend <= 1'b0;
        state <= UNLOCKED;
        mcnt <= '0;
        tcnt <= '0;
      end else begin
        pend <= pend_eff & ~load;
        if (load) begin
          tcnt <= '0;
          mcnt <= ~match ? '0 : (mcnt == MW'(LOCK_CNT)) ? mcnt : mcnt + 1'b1;
          state <= (match && mcnt >= MW'(LOCK_CNT-1)) ? LOCKED : TRACK;
        end else if (adv) begin
          tcnt <= timeout ? tcnt : tcnt + 1'b1;
          if (timeout) begin
            state <= UNLOCKED;
            mcnt <= '0;
          end
        end
      end
    end
  end
`else
  logic unused_ext;
  assign unused_ext = i_DLCLK_n ^ i_SLAVE;
  assign load = 1'b0;
  assign o_LOCKED = ~o_RST_INT;
`endif
endmodule
